// File: rtl/regfile_mp.sv
// Multi-port register file with write-through bypass and a per-register
// pending scoreboard for read-after-write hazard detection.
module regfile_mp #(
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NR       = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NR*AW-1:0]   r_addr_i,
  input  logic [NR-1:0]      r_rd_i,
  output logic [NR*DW-1:0]   r_data_o,
  output logic [NR-1:0]      r_busy_o,
  input  logic               we0_i,
  input  logic [AW-1:0]      w_addr0_i,
  input  logic [DW-1:0]      w_data0_i,
  input  logic               we1_i,
  input  logic [AW-1:0]      w_addr1_i,
  input  logic [DW-1:0]      w_data1_i,
  input  logic               iss_i,
  input  logic [AW-1:0]      i_addr_i,
  output logic [AW:0]        pend_cnt_o
);

  localparam int unsigned Depth = 1 << AW;

  logic [DW-1:0]    regs_q [Depth];
  logic [Depth-1:0] pend_q, pend_d;
  logic [Depth-1:0] clr_mask;
  logic [Depth-1:0] busy_vec;
  logic [AW:0]      pend_cnt_q, pend_cnt_d;
  logic             w0_ok, w1_ok, iss_ok;

  // Writes and issues to register 0 are dropped when it is hard-wired to zero.
  assign w0_ok  = we0_i && !(ZERO_REG != 0 && w_addr0_i == '0);
  assign w1_ok  = we1_i && !(ZERO_REG != 0 && w_addr1_i == '0);
  assign iss_ok = iss_i && !(ZERO_REG != 0 && i_addr_i == '0);

  // Storage update; port 1 is assigned last so it wins on a collision.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < Depth; k++) regs_q[k] <= '0;
    end else begin
      if (w0_ok) regs_q[w_addr0_i] <= w_data0_i;
      if (w1_ok) regs_q[w_addr1_i] <= w_data1_i;
    end
  end

  // Clears from this cycle's writebacks, then the issue set (a new producer wins).
  always_comb begin
    clr_mask = '0;
    if (w0_ok) clr_mask[w_addr0_i] = 1'b1;
    if (w1_ok) clr_mask[w_addr1_i] = 1'b1;
    pend_d = pend_q & ~clr_mask;
    if (iss_ok) pend_d[i_addr_i] = 1'b1;
  end

  // Exact popcount of the next-state pending vector.
  always_comb begin
    pend_cnt_d = '0;
    for (int k = 0; k < Depth; k++) begin
      pend_cnt_d = pend_cnt_d + {{AW{1'b0}}, pend_d[k]};
    end
  end

  // Scoreboard state and registered pending count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign pend_cnt_o = pend_cnt_q;

  // With bypass, a register written this cycle already reads as not busy.
  assign busy_vec = (BYPASS != 0) ? (pend_q & ~clr_mask) : pend_q;

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
    logic          rbusy;

    assign addr = r_addr_i[i*AW +: AW];

    // Per-port read mux: gate, zero register, bypass (port 1 first), then storage.
    always_comb begin
      rdata = '0;
      rbusy = 1'b0;
      if (r_rd_i[i] && !(ZERO_REG != 0 && addr == '0)) begin
        rbusy = busy_vec[addr];
        if (BYPASS != 0 && we1_i && w_addr1_i == addr) begin
          rdata = w_data1_i;
        end else if (BYPASS != 0 && we0_i && w_addr0_i == addr) begin
          rdata = w_data0_i;
        end else begin
          rdata = regs_q[addr];
        end
      end
    end

    assign r_data_o[i*DW +: DW] = rdata;
    assign r_busy_o[i]          = rbusy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against a behavioural model.
module tb_regfile_mp;

  logic clk, rst_n;

  // Default configuration: DW=32 AW=5 NR=2 ZERO_REG=1 BYPASS=1
  logic [9:0]  r_addr;
  logic [1:0]  r_rd;
  logic [63:0] r_data;
  logic [1:0]  r_busy;
  logic        we0, we1, iss;
  logic [4:0]  wa0, wa1, ia;
  logic [31:0] wd0, wd1;
  logic [5:0]  pcnt;

  // Sweep configuration: AW=3 NR=4 ZERO_REG=0 BYPASS=0
  logic [11:0]  s_addr;
  logic [3:0]   s_rd;
  logic [127:0] s_data;
  logic [3:0]   s_busy;
  logic         s_we0, s_we1, s_iss;
  logic [2:0]   s_wa0, s_wa1, s_ia;
  logic [31:0]  s_wd0, s_wd1;
  logic [3:0]   s_pcnt;

  regfile_mp u_dut (
    .clk_i(clk), .rst_ni(rst_n), .r_addr_i(r_addr), .r_rd_i(r_rd), .r_data_o(r_data),
    .r_busy_o(r_busy), .we0_i(we0), .w_addr0_i(wa0), .w_data0_i(wd0), .we1_i(we1),
    .w_addr1_i(wa1), .w_data1_i(wd1), .iss_i(iss), .i_addr_i(ia), .pend_cnt_o(pcnt)
  );

  regfile_mp #(.DW(32), .AW(3), .NR(4), .ZERO_REG(0), .BYPASS(0)) u_sweep (
    .clk_i(clk), .rst_ni(rst_n), .r_addr_i(s_addr), .r_rd_i(s_rd), .r_data_o(s_data),
    .r_busy_o(s_busy), .we0_i(s_we0), .w_addr0_i(s_wa0), .w_data0_i(s_wd0), .we1_i(s_we1),
    .w_addr1_i(s_wa1), .w_data1_i(s_wd1), .iss_i(s_iss), .i_addr_i(s_ia), .pend_cnt_o(s_pcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_reg [32];
  bit          m_pend [32];
  logic [31:0] s_m [8];
  bit          s_p [8];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 32; k++) begin m_reg[k] = '0; m_pend[k] = 0; end
    for (int k = 0; k < 8; k++) begin s_m[k] = '0; s_p[k] = 0; end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int k = 0; k < 32; k++) c += int'(m_pend[k]);
    return c;
  endfunction

  function automatic int s_count();
    int c = 0;
    for (int k = 0; k < 8; k++) c += int'(s_p[k]);
    return c;
  endfunction

  // Expected read data of main-instance port p from the current model and inputs.
  function automatic logic [31:0] exp_data(int p);
    logic [4:0] a = r_addr[p*5 +: 5];
    if (!r_rd[p] || a == 0) return 32'h0;
    if (we1 && wa1 == a) return wd1;
    if (we0 && wa0 == a) return wd0;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(int p);
    logic [4:0] a = r_addr[p*5 +: 5];
    if (!r_rd[p] || a == 0) return 1'b0;
    if ((we0 && wa0 == a) || (we1 && wa1 == a)) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic check_reads();
    for (int p = 0; p < 2; p++) begin
      check_eq($sformatf("rdata%0d", p), r_data[p*32 +: 32], exp_data(p));
      check_eq($sformatf("rbusy%0d", p), r_busy[p], exp_busy(p));
    end
  endtask

  // Called with inputs driven in the low phase: check reads, clock, update model.
  task automatic tick();
    #1 check_reads();
    @(posedge clk);
    if (we0 && wa0 != 0) m_reg[wa0] = wd0;
    if (we1 && wa1 != 0) m_reg[wa1] = wd1;
    if (we0) m_pend[wa0] = 0;
    if (we1) m_pend[wa1] = 0;
    if (iss && ia != 0) m_pend[ia] = 1;
    #1 check_eq("pend_cnt", pcnt, m_count());
    @(negedge clk);
    we0 = 0; we1 = 0; iss = 0;
  endtask

  task automatic s_tick();
    @(posedge clk);
    if (s_we0) s_m[s_wa0] = s_wd0;
    if (s_we1) s_m[s_wa1] = s_wd1;
    if (s_we0) s_p[s_wa0] = 0;
    if (s_we1) s_p[s_wa1] = 0;
    if (s_iss) s_p[s_ia] = 1;
    #1 check_eq("s_pend_cnt", s_pcnt, s_count());
    @(negedge clk);
    s_we0 = 0; s_we1 = 0; s_iss = 0;
  endtask

  task automatic s_check_reads();
    for (int p = 0; p < 4; p++) begin
      logic [2:0] a = s_addr[p*3 +: 3];
      check_eq($sformatf("s_rdata%0d", p), s_data[p*32 +: 32], s_rd[p] ? s_m[a] : 32'h0);
      check_eq($sformatf("s_rbusy%0d", p), s_busy[p], s_rd[p] ? s_p[a] : 1'b0);
    end
  endtask

  initial begin
    rst_n = 0;
    we0 = 0; we1 = 0; iss = 0; wa0 = 0; wa1 = 0; ia = 0; wd0 = 0; wd1 = 0;
    r_addr = {5'd3, 5'd5}; r_rd = 2'b11;
    s_we0 = 0; s_we1 = 0; s_iss = 0; s_wa0 = 0; s_wa1 = 0; s_ia = 0; s_wd0 = 0; s_wd1 = 0;
    s_addr = '0; s_rd = '0;
    model_reset();
    #2;
    check_eq("reset_rdata", r_data, 64'h0);
    check_eq("reset_rbusy", r_busy, 2'b00);
    check_eq("reset_pcnt", pcnt, 6'd0);
    @(negedge clk);
    rst_n = 1;

    // Dual-write collision on r3: port 1 wins, also through the bypass.
    we0 = 1; wa0 = 5'd3; wd0 = 32'h11; we1 = 1; wa1 = 5'd3; wd1 = 32'h22;
    r_addr = {5'd4, 5'd3}; r_rd = 2'b11;
    #1 check_eq("collide_bypass", r_data[31:0], 32'h22);
    tick();
    #1 check_eq("collide_stored", r_data[31:0], 32'h22);
    tick();

    // Zero register ignores writes and issues.
    we0 = 1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF; iss = 1; ia = 5'd0; r_addr = {5'd0, 5'd0};
    tick();
    #1 check_eq("zero_rdata", r_data[31:0], 32'h0);
    check_eq("zero_rbusy", r_busy[0], 1'b0);
    check_eq("zero_pcnt", pcnt, 6'd0);
    tick();

    // Scoreboard lifecycle on r7.
    iss = 1; ia = 5'd7; r_addr = {5'd0, 5'd7};
    tick();
    #1 check_eq("life_busy", r_busy[0], 1'b1);
    check_eq("life_pcnt1", pcnt, 6'd1);
    tick();
    tick();
    we0 = 1; wa0 = 5'd7; wd0 = 32'h1234;
    #1 check_eq("life_bypass_busy", r_busy[0], 1'b0);
    check_eq("life_bypass_data", r_data[31:0], 32'h1234);
    tick();
    check_eq("life_pcnt0", pcnt, 6'd0);

    // Set/clear race on r9: issue beats the clearing write.
    iss = 1; ia = 5'd9; r_addr = {5'd0, 5'd9};
    tick();
    iss = 1; ia = 5'd9; we0 = 1; wa0 = 5'd9; wd0 = 32'h55;
    tick();
    #1 check_eq("race_busy", r_busy[0], 1'b1);
    check_eq("race_pcnt", pcnt, 6'd1);
    tick();

    // Mid-cycle reset after writing r5.
    we0 = 1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF; iss = 1; ia = 5'd8; r_addr = {5'd8, 5'd5};
    tick();
    #1 check_eq("pre_reset_r5", r_data[31:0], 32'hDEAD_BEEF);
    #1 rst_n = 0;
    #1 check_eq("midreset_r5", r_data[31:0], 32'h0);
    check_eq("midreset_pcnt", pcnt, 6'd0);
    check_eq("midreset_busy", r_busy, 2'b00);
    model_reset();
    #1 rst_n = 1;
    @(negedge clk);

    // Random traffic, read addresses biased towards the write addresses.
    for (int n = 0; n < 400; n++) begin
      we0 = 1'($urandom_range(0, 1)); wa0 = 5'($urandom_range(0, 31)); wd0 = $urandom;
      we1 = ($urandom_range(0, 3) == 0); wa1 = ($urandom_range(0, 3) == 0) ? wa0 :
                                              5'($urandom_range(0, 31));
      wd1 = $urandom;
      iss = ($urandom_range(0, 2) != 0); ia = ($urandom_range(0, 5) == 0) ? wa0 :
                                             5'($urandom_range(0, 31));
      r_rd = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        case ($urandom_range(0, 3))
          0: r_addr[p*5 +: 5] = wa0;
          1: r_addr[p*5 +: 5] = wa1;
          default: r_addr[p*5 +: 5] = 5'($urandom_range(0, 31));
        endcase
      end
      tick();
    end

    // Sweep configuration: fill, issue everything, read back with no bypass.
    for (int k = 0; k < 8; k++) begin
      s_we0 = 1; s_wa0 = 3'(k); s_wd0 = $urandom;
      s_tick();
    end
    for (int k = 0; k < 8; k++) begin
      s_iss = 1; s_ia = 3'(k);
      s_tick();
    end
    check_eq("sweep_pcnt8", s_pcnt, 4'd8);
    s_rd = 4'hF;
    for (int k = 0; k < 8; k++) begin
      s_addr = {4{3'(k)}};
      #1 s_check_reads();
      #1;
    end
    s_we0 = 1; s_wa0 = 3'd2; s_wd0 = 32'hCAFE_F00D; s_addr = {4{3'd2}};
    #1 s_check_reads();
    check_eq("sweep_nobypass_busy", s_busy, 4'hF);
    s_tick();
    #1 s_check_reads();
    check_eq("sweep_after_write", s_data[31:0], 32'hCAFE_F00D);
    check_eq("sweep_pcnt7", s_pcnt, 4'd7);
    for (int n = 0; n < 100; n++) begin
      s_we0 = 1'($urandom_range(0, 1)); s_wa0 = 3'($urandom_range(0, 7)); s_wd0 = $urandom;
      s_we1 = 1'($urandom_range(0, 1)); s_wa1 = 3'($urandom_range(0, 7)); s_wd1 = $urandom;
      s_iss = 1'($urandom_range(0, 1)); s_ia = 3'($urandom_range(0, 7));
      s_rd = 4'($urandom_range(0, 15));
      for (int p = 0; p < 4; p++) s_addr[p*3 +: 3] = 3'($urandom_range(0, 7));
      #1 s_check_reads();
      s_tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file with write-through bypass and a per-register pending scoreboard. It is the successor to the two-read/one-write register file between IDU and WBU. It serves any number of IDU read ports and two writeback ports (ALU path, load path). The scoreboard lets IDU detect read-after-write hazards without an external hazard table.

## Interface
- DW, 32: data width in bits
- AW, 5: address width; depth = 2**AW
- NR, 2: number of read ports (1..8)
- ZERO_REG, 1: when 1, register 0 reads as 0, ignores writes, and is never pending
- BYPASS, 1: when 1, a same-cycle write to the read address is forwarded to the read data

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- rAddr  in  NR*AW  read addresses; port i at [i*AW +: AW]
- rRd  in  NR  per-port read enable
- rData  out  NR*DW  read data; port i at [i*DW +: DW]
- rBusy  out  NR  port i's register has a pending write (qualified by rRd)
- we0 / wAddr0 / wData0  in  1 / AW / DW  write port 0 (ALU writeback)
- we1 / wAddr1 / wData1  in  1 / AW / DW  write port 1 (load writeback); higher priority
- iss  in  1  issue strobe: mark iAddr pending
- iAddr  in  AW  destination register of the issuing instruction
- pendCnt  out  AW+1  number of registers currently pending (registered)

## Operation
- Storage: 2**AW x DW flops and a 2**AW pending-bit vector.
- Reset (rst low, asynchronous): all registers are 0, all pending bits are 0, pendCnt = 0. Read outputs follow combinationally, so rData = 0 and rBusy = 0.
- Write on rising edge:
  - weK=1 writes wDataK to wAddrK.
  - Both ports to the same address: port 1 wins.
  - ZERO_REG=1 and address 0: the write is dropped.
- Read is combinational, per port i:
  - rRd[i]=0: rData=0, rBusy=0.
  - ZERO_REG=1 and address 0: rData=0, rBusy=0.
  - Otherwise the priority is:
    1. BYPASS=1, we1 active and wAddr1 matches: rData=wData1.
    2. BYPASS=1, we0 active and wAddr0 matches: rData=wData0.
    3. Stored value.
- Scoreboard:
  - iss=1 sets pending[iAddr] at the edge.
  - weK=1 clears pending[wAddrK] at the edge.
  - Set and clear on the same address in the same cycle: set wins, because a new producer supersedes.
  - iss on an already-pending register: it stays pending, with no count change.
  - ZERO_REG=1: iss to address 0 is ignored.
- rBusy[i] = pending[rAddr[i]] after applying the current cycle's clears when BYPASS=1. A register being written this cycle therefore reads not-busy with the forwarded data. With BYPASS=0, rBusy uses the stored pending bit only.
- pendCnt is a registered popcount of the next-state pending vector. It updates on the same edge as the bits and is exact, never saturating. Maximum value is 2**AW, or 2**AW-1 when ZERO_REG=1.

## Timing
- Read latency is 0 cycles (combinational from rAddr/rRd and write ports when BYPASS=1).
- Write latency is 1 edge. With BYPASS=0, data is visible on reads the cycle after the write.
- Scoreboard latency is 1 edge. Issue at edge N gives rBusy=1 from cycle N+1 until the edge that writes the register.
- Reset asserted mid-operation: state clears immediately, independent of clk. Writes and issues in that cycle are lost. The first write is accepted at the first rising edge after rst is released.
- Write or issue to an out-of-range address cannot occur, since the address is full width.

## Test plan
- Reset: write 0xDEADBEEF to r5, then pulse rst low mid-cycle. rData for r5 is 0 before the next edge, and pendCnt is 0.
- Dual-write collision: we0 with wAddr0=3, wData0=0x11 and we1 with wAddr1=3, wData1=0x22 in the same cycle. r3 reads 0x22 afterward. A same-cycle read with BYPASS=1 also returns 0x22.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to r0 and iss with iAddr=0. r0 reads 0, rBusy=0, pendCnt stays 0.
- Scoreboard lifecycle:
  - Cycle 0: iss r7. Cycle 1: rBusy=1, pendCnt=1.
  - Cycle 3: we0 r7 with 0x1234. That cycle: rBusy=0 and rData=0x1234 (bypass). Cycle 4: pendCnt=0.
- Set/clear race: r9 pending, then iss r9 and we0 r9 in the same cycle. r9 stays pending and pendCnt is unchanged.
- Parameter sweep: run AW=3, NR=4, BYPASS=0, ZERO_REG=0. Issue all 8 registers, giving pendCnt=8. Read each on all 4 ports against a reference model, with no bypass.
